// File: rtl/riscv_wb_arbiter.sv
// Two-port Wishbone B4 (pipelined) arbiter: IFU and LSU share one master port with
// whole-cycle grants, round-robin ties, an outstanding-strobe limit and a hung-cycle timeout.
//
// state   | meaning
// IDLE    | no owner; picks the next requester (registered grant)
// OWN_I   | instruction port drives the master port
// OWN_D   | data port drives the master port
// ABORT   | timed-out cycle; owner gets one err pulse, waits for its cyc to drop
module riscv_wb_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,

  input  logic        wb_i_cyc_i,
  input  logic        wb_i_stb_i,
  input  logic        wb_i_we_i,
  input  logic [29:0] wb_i_addr_i,
  input  logic [3:0]  wb_i_sel_i,
  input  logic [31:0] wb_i_data_i,
  output logic        wb_i_ack_o,
  output logic        wb_i_stall_o,
  output logic        wb_i_err_o,
  output logic [31:0] wb_i_data_o,

  input  logic        wb_d_cyc_i,
  input  logic        wb_d_stb_i,
  input  logic        wb_d_we_i,
  input  logic [29:0] wb_d_addr_i,
  input  logic [3:0]  wb_d_sel_i,
  input  logic [31:0] wb_d_data_i,
  output logic        wb_d_ack_o,
  output logic        wb_d_stall_o,
  output logic        wb_d_err_o,
  output logic [31:0] wb_d_data_o,

  output logic        wb_m_cyc_o,
  output logic        wb_m_stb_o,
  output logic        wb_m_we_o,
  output logic [29:0] wb_m_addr_o,
  output logic [3:0]  wb_m_sel_o,
  output logic [31:0] wb_m_data_o,
  input  logic        wb_m_ack_i,
  input  logic        wb_m_stall_i,
  input  logic        wb_m_err_i,
  input  logic [31:0] wb_m_data_i
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OWN_I, S_OWN_D, S_ABORT} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;       // 1 = data port was the last owner
  logic          own_q, own_d;         // 1 = data port is the current owner
  logic          abort_err_q, abort_err_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [TW-1:0] timer_q, timer_d;

  logic        own_cyc, own_stb, own_we;
  logic [29:0] own_addr;
  logic [3:0]  own_sel;
  logic [31:0] own_data;
  logic        owning, full, accept, resp, timeout_hit, inc, dec;

  assign owning      = (state_q == S_OWN_I) || (state_q == S_OWN_D);
  assign full        = (outst_q == OW'(MAX_OUTSTANDING));
  assign accept      = wb_m_stb_o && !wb_m_stall_i;
  assign resp        = wb_m_ack_i || wb_m_err_i;
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));

  always_comb begin
    if (own_q) begin
      own_cyc  = wb_d_cyc_i;
      own_stb  = wb_d_stb_i;
      own_we   = wb_d_we_i;
      own_addr = wb_d_addr_i;
      own_sel  = wb_d_sel_i;
      own_data = wb_d_data_i;
    end else begin
      own_cyc  = wb_i_cyc_i;
      own_stb  = wb_i_stb_i;
      own_we   = wb_i_we_i;
      own_addr = wb_i_addr_i;
      own_sel  = wb_i_sel_i;
      own_data = wb_i_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      own_q       <= 1'b0;
      abort_err_q <= 1'b0;
      outst_q     <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      own_q       <= own_d;
      abort_err_q <= abort_err_d;
      outst_q     <= outst_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb_i_cyc_i && (!wb_d_cyc_i || last_q)) begin
          state_d = S_OWN_I;
          own_d   = 1'b0;
        end else if (wb_d_cyc_i) begin
          state_d = S_OWN_D;
          own_d   = 1'b1;
        end
      end
      S_OWN_I, S_OWN_D: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          last_d  = own_q;
        end else if (timeout_hit) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (!own_cyc) begin
          state_d = S_IDLE;
          last_d  = own_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dropping cyc (or aborting) discards anything still in flight.
  always_comb begin
    outst_d     = '0;
    timer_d     = '0;
    abort_err_d = 1'b0;
    inc         = accept;
    dec         = resp && (outst_q != '0);
    if (owning && own_cyc) begin
      if (timeout_hit) begin
        abort_err_d = 1'b1;
      end else begin
        outst_d = outst_q;
        if (inc && !dec) begin
          outst_d = outst_q + 1'b1;
        end else if (dec && !inc) begin
          outst_d = outst_q - 1'b1;
        end
        if (!resp && (outst_d != '0)) begin
          timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    wb_m_cyc_o   = 1'b0;
    wb_m_stb_o   = 1'b0;
    wb_m_we_o    = 1'b0;
    wb_m_addr_o  = '0;
    wb_m_sel_o   = '0;
    wb_m_data_o  = '0;
    wb_i_ack_o   = 1'b0;
    wb_i_err_o   = 1'b0;
    wb_i_stall_o = 1'b1;
    wb_d_ack_o   = 1'b0;
    wb_d_err_o   = 1'b0;
    wb_d_stall_o = 1'b1;
    wb_i_data_o  = wb_m_data_i;
    wb_d_data_o  = wb_m_data_i;
    if (owning) begin
      wb_m_cyc_o  = own_cyc;
      wb_m_stb_o  = own_cyc && own_stb && !full;
      wb_m_we_o   = own_we;
      wb_m_addr_o = own_addr;
      wb_m_sel_o  = own_sel;
      wb_m_data_o = own_data;
      if (own_q) begin
        wb_d_ack_o   = wb_m_ack_i && own_cyc;
        wb_d_err_o   = wb_m_err_i && own_cyc;
        wb_d_stall_o = wb_m_stall_i || full;
      end else begin
        wb_i_ack_o   = wb_m_ack_i && own_cyc;
        wb_i_err_o   = wb_m_err_i && own_cyc;
        wb_i_stall_o = wb_m_stall_i || full;
      end
    end else if (state_q == S_ABORT) begin
      if (own_q) begin
        wb_d_err_o = abort_err_q;
      end else begin
        wb_i_err_o = abort_err_q;
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: single fetch, slave error, timeout abort,
// async reset with round-robin ties, and the outstanding-strobe limit.
module tb_riscv_wb_arbiter;
  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        i_cyc, i_stb, i_we, i_ack, i_stall, i_err;
  logic [29:0] i_addr;
  logic [3:0]  i_sel;
  logic [31:0] i_wdata, i_rdata;
  logic        d_cyc, d_stb, d_we, d_ack, d_stall, d_err;
  logic [29:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata, d_rdata;
  logic        m_cyc, m_stb, m_we, m_ack, m_stall, m_err;
  logic [29:0] m_addr;
  logic [3:0]  m_sel;
  logic [31:0] m_wdata, m_rdata;

  int n_chk = 0;
  int n_err = 0;
  int n_acc;
  logic [15:0] stb_in_v, ack_v, exp_stall_v, exp_stb_v;

  always #5 clk_i = ~clk_i;

  riscv_wb_arbiter #(.MAX_OUTSTANDING(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .wb_i_cyc_i(i_cyc), .wb_i_stb_i(i_stb), .wb_i_we_i(i_we), .wb_i_addr_i(i_addr),
    .wb_i_sel_i(i_sel), .wb_i_data_i(i_wdata), .wb_i_ack_o(i_ack), .wb_i_stall_o(i_stall),
    .wb_i_err_o(i_err), .wb_i_data_o(i_rdata),
    .wb_d_cyc_i(d_cyc), .wb_d_stb_i(d_stb), .wb_d_we_i(d_we), .wb_d_addr_i(d_addr),
    .wb_d_sel_i(d_sel), .wb_d_data_i(d_wdata), .wb_d_ack_o(d_ack), .wb_d_stall_o(d_stall),
    .wb_d_err_o(d_err), .wb_d_data_o(d_rdata),
    .wb_m_cyc_o(m_cyc), .wb_m_stb_o(m_stb), .wb_m_we_o(m_we), .wb_m_addr_o(m_addr),
    .wb_m_sel_o(m_sel), .wb_m_data_o(m_wdata), .wb_m_ack_i(m_ack), .wb_m_stall_i(m_stall),
    .wb_m_err_i(m_err), .wb_m_data_i(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_ni = 1'b0;
    i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_addr = '0; i_sel = 4'hf; i_wdata = '0;
    d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_addr = '0; d_sel = 4'hf; d_wdata = '0;
    m_ack = 1'b0; m_stall = 1'b0; m_err = 1'b0; m_rdata = '0;
    stb_in_v    = 16'h01FE;
    ack_v       = 16'h33C0;
    exp_stall_v = 16'h0060;
    exp_stb_v   = 16'h019E;

    #2;
    chk("rst_m_cyc", 32'(m_cyc), 32'h0);
    chk("rst_m_stb", 32'(m_stb), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_i_stall", 32'(i_stall), 32'h1);
    chk("rst_d_stall", 32'(d_stall), 32'h1);
    chk("rst_i_ack", 32'(i_ack), 32'h0);
    chk("rst_d_err", 32'(d_err), 32'h0);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    step();

    // single instruction fetch
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 30'h10;
    settle();
    chk("i1_req_stall", 32'(i_stall), 32'h1);
    chk("i1_req_mcyc", 32'(m_cyc), 32'h0);
    step(); settle();
    chk("i1_m_cyc", 32'(m_cyc), 32'h1);
    chk("i1_m_stb", 32'(m_stb), 32'h1);
    chk("i1_m_addr", 32'(m_addr), 32'h10);
    chk("i1_i_stall", 32'(i_stall), 32'h0);
    chk("i1_d_stall", 32'(d_stall), 32'h1);
    step(); i_stb = 1'b0; settle();
    chk("i1_no_ack", 32'(i_ack), 32'h0);
    step(); m_ack = 1'b1; m_rdata = 32'h0000_0013; settle();
    chk("i1_ack", 32'(i_ack), 32'h1);
    chk("i1_data", i_rdata, 32'h0000_0013);
    chk("i1_d_ack", 32'(d_ack), 32'h0);
    chk("i1_d_stall_ack", 32'(d_stall), 32'h1);
    step(); m_ack = 1'b0; i_cyc = 1'b0; settle();
    chk("i1_rel_cyc", 32'(m_cyc), 32'h0);
    step(); settle();
    chk("i1_idle_stall", 32'(i_stall), 32'h1);

    // slave error on the second of three reads
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 30'h20;
    step(); settle();
    chk("e_addr0", 32'(m_addr), 32'h20);
    step(); i_addr = 30'h21; settle();
    chk("e_addr1", 32'(m_addr), 32'h21);
    step(); i_addr = 30'h22; m_ack = 1'b1; m_rdata = 32'h31; settle();
    chk("e_ack1", 32'(i_ack), 32'h1);
    chk("e_noerr1", 32'(i_err), 32'h0);
    step(); i_stb = 1'b0; m_ack = 1'b0; m_err = 1'b1; settle();
    chk("e_err", 32'(i_err), 32'h1);
    chk("e_err_noack", 32'(i_ack), 32'h0);
    chk("e_err_cyc", 32'(m_cyc), 32'h1);
    chk("e_err_d", 32'(d_err), 32'h0);
    step(); m_err = 1'b0; m_ack = 1'b1; m_rdata = 32'h33; settle();
    chk("e_ack3", 32'(i_ack), 32'h1);
    chk("e_data3", i_rdata, 32'h33);
    chk("e_cyc3", 32'(m_cyc), 32'h1);
    chk("e_stall3", 32'(i_stall), 32'h0);
    step(); m_ack = 1'b0; i_cyc = 1'b0;
    step();

    // timeout: one strobe, never acknowledged
    i_cyc = 1'b1; i_stb = 1'b1; i_addr = 30'h80;
    step(); settle();
    chk("t_acc_stb", 32'(m_stb), 32'h1);
    step(); i_stb = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      settle();
      chk("t_wait_cyc", 32'(m_cyc), 32'h1);
      chk("t_wait_err", 32'(i_err), 32'h0);
      step();
    end
    m_ack = 1'b1; settle();
    chk("t_abort_cyc", 32'(m_cyc), 32'h0);
    chk("t_abort_err", 32'(i_err), 32'h1);
    chk("t_late_ack", 32'(i_ack), 32'h0);
    chk("t_abort_stall", 32'(i_stall), 32'h1);
    chk("t_abort_d_err", 32'(d_err), 32'h0);
    step(); m_ack = 1'b0; settle();
    chk("t_err_pulse", 32'(i_err), 32'h0);
    chk("t_abort_cyc2", 32'(m_cyc), 32'h0);
    step(); i_cyc = 1'b0;
    step(); i_cyc = 1'b1;
    step(); settle();
    chk("t_regrant_stall", 32'(i_stall), 32'h0);
    chk("t_regrant_cyc", 32'(m_cyc), 32'h1);
    i_cyc = 1'b0;
    step();

    // async reset while the data port has two strobes in flight
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 30'h60;
    step(); settle();
    chk("r_own_d", 32'(d_stall), 32'h0);
    step(); d_addr = 30'h61;
    step(); d_stb = 1'b0; settle();
    chk("r_out_cyc", 32'(m_cyc), 32'h1);
    reset_ni = 1'b0; settle();
    chk("r_rst_cyc", 32'(m_cyc), 32'h0);
    chk("r_rst_i_stall", 32'(i_stall), 32'h1);
    chk("r_rst_d_stall", 32'(d_stall), 32'h1);
    chk("r_rst_stb", 32'(m_stb), 32'h0);
    d_cyc = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;

    // ties alternate I, D, I, D starting with I out of reset
    i_cyc = 1'b1; d_cyc = 1'b1; i_addr = 30'h100; d_addr = 30'h200;
    for (int k = 0; k < 4; k++) begin
      step(); settle();
      chk("rr_addr", 32'(m_addr), k[0] ? 32'h200 : 32'h100);
      chk("rr_i_stall", 32'(i_stall), 32'(k[0]));
      chk("rr_d_stall", 32'(d_stall), 32'(!k[0]));
      if (k[0]) d_cyc = 1'b0; else i_cyc = 1'b0;
      settle();
      chk("rr_release", 32'(m_cyc), 32'h0);
      step(); i_cyc = 1'b1; d_cyc = 1'b1; settle();
      chk("rr_gap_i", 32'(i_stall), 32'h1);
      chk("rr_gap_d", 32'(d_stall), 32'h1);
    end
    i_cyc = 1'b0; d_cyc = 1'b0;
    step();

    // six pipelined data strobes, acks five cycles after acceptance
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 30'h40; n_acc = 0;
    for (int j = 1; j <= 13; j++) begin
      step();
      d_stb   = stb_in_v[j[3:0]];
      d_addr  = 30'h40 + 30'(n_acc);
      m_ack   = ack_v[j[3:0]];
      m_rdata = 32'hD000 + 32'(j);
      settle();
      chk("p_d_stall", 32'(d_stall), 32'(exp_stall_v[j[3:0]]));
      chk("p_m_stb", 32'(m_stb), 32'(exp_stb_v[j[3:0]]));
      chk("p_d_ack", 32'(d_ack), 32'(ack_v[j[3:0]]));
      chk("p_i_stall", 32'(i_stall), 32'h1);
      if (exp_stb_v[j[3:0]]) begin
        chk("p_m_addr", 32'(m_addr), 32'h40 + 32'(n_acc));
        n_acc++;
      end
      if (ack_v[j[3:0]]) chk("p_d_data", d_rdata, 32'hD000 + 32'(j));
    end
    step(); m_ack = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; settle();
    chk("p_rel_cyc", 32'(m_cyc), 32'h0);
    step(); settle();
    chk("p_idle_stall", 32'(d_stall), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
